// File: rtl/mic_clk_gen.sv
// mic_clk_gen: runtime-programmable microphone clock generator.
// Derives a 50%-duty bit clock (sck) and a frame word-select (ws) from clk_in.
// The ratios are programmable through a valid/ready config port. While the
// generator runs, a new config is held pending and only takes effect at a
// frame boundary. A lock-gated sequencer holds rst_mic_n low until
// RST_HOLD_FRAMES frames have started with the PLL locked.
//
// Ports:
//   clk_in        sole clock
//   rst_n         asynchronous active-low reset
//   pll_lock      PLL lock, asynchronous; passed through a 2-flop synchroniser
//   en            run request
//   cfg_valid     config offer
//   cfg_ready     config accept-ready (low while a config is pending)
//   cfg_sck_half  requested sck half-period in clk_in cycles (0 -> 1)
//   cfg_ws_ratio  requested sck periods per frame (forced even, >= 2)
//   sck           bit clock
//   sck_rise      high in the first cycle sck is 1
//   sck_fall      high in the first cycle sck is 0 after a high phase
//   ws            word select, 0 = first half-frame
//   ws_start      one-cycle frame-start strobe
//   rst_mic_n     downstream reset, active low
//   busy          high while running or finishing the last frame
module mic_clk_gen #(
  parameter int unsigned DIV_W           = 8,
  parameter int unsigned RATIO_W         = 8,
  parameter int unsigned DEF_SCK_HALF    = 5,
  parameter int unsigned DEF_WS_RATIO    = 64,
  parameter int unsigned RST_HOLD_FRAMES = 4
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIV_W-1:0]   cfg_sck_half,
  input  logic [RATIO_W-1:0] cfg_ws_ratio,
  output logic               sck,
  output logic               sck_rise,
  output logic               sck_fall,
  output logic               ws,
  output logic               ws_start,
  output logic               rst_mic_n,
  output logic               busy
);

  localparam int unsigned     FC_W = $clog2(RST_HOLD_FRAMES + 1);
  localparam logic [FC_W-1:0] HOLD = FC_W'(RST_HOLD_FRAMES);

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  state_t state, state_n;

  logic               lock_meta, lock_s;
  logic [DIV_W-1:0]   act_half, pend_half, san_half;
  logic [DIV_W-1:0]   half_cnt, half_cnt_n;
  logic [RATIO_W-1:0] act_ratio, pend_ratio, san_ratio;
  logic [RATIO_W-1:0] bit_cnt, bit_cnt_n;
  logic               pend_valid;
  logic [FC_W-1:0]    frame_cnt;
  logic               tick, fall_tick, boundary, frame_start;
  logic               accept, apply, sck_n, ws_n;

  assign cfg_ready = ~pend_valid;
  assign busy      = (state != OFF);
  assign accept    = cfg_valid & ~pend_valid;

  // Sanitise the offered config: half >= 1, ratio even and >= 2.
  always_comb begin
    san_half  = (cfg_sck_half == '0) ? DIV_W'(1) : cfg_sck_half;
    san_ratio = {cfg_ws_ratio[RATIO_W-1:1], 1'b0};
    if (san_ratio < RATIO_W'(2)) san_ratio = RATIO_W'(2);
  end

  // Next state. A frame boundary is the sck falling toggle that ends the
  // last bit of the frame; whether the next frame starts is decided by en
  // at that point, so a stop never truncates a frame.
  always_comb begin
    tick        = (half_cnt == act_half - DIV_W'(1));
    fall_tick   = tick & sck;
    boundary    = fall_tick & (bit_cnt == act_ratio - RATIO_W'(1));
    state_n     = state;
    frame_start = 1'b0;
    unique case (state)
      OFF: begin
        if (en && lock_s) begin
          state_n     = RUN;
          frame_start = 1'b1;
        end
      end
      RUN, STOP_PEND: begin
        if (!lock_s) begin
          state_n = OFF;
        end else if (boundary) begin
          state_n     = en ? RUN : OFF;
          frame_start = en;
        end else begin
          state_n = en ? RUN : STOP_PEND;
        end
      end
      default: state_n = OFF;
    endcase
  end

  // Pending config lands at every boundary (including the one that stops the
  // generator) and on entry from OFF, but never on lock loss.
  assign apply = pend_valid & lock_s &
                 (((state == OFF) & en) | ((state != OFF) & boundary));

  // Counter / output next values.
  always_comb begin
    half_cnt_n = '0;
    bit_cnt_n  = '0;
    sck_n      = 1'b0;
    ws_n       = 1'b0;
    if (state_n != OFF && !frame_start) begin
      half_cnt_n = tick ? '0 : half_cnt + DIV_W'(1);
      sck_n      = tick ? ~sck : sck;
      bit_cnt_n  = bit_cnt;
      ws_n       = ws;
      if (fall_tick) begin
        bit_cnt_n = bit_cnt + RATIO_W'(1);
        ws_n      = (bit_cnt_n >= (act_ratio >> 1));
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= OFF;
    else        state <= state_n;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta  <= 1'b0;
      lock_s     <= 1'b0;
      half_cnt   <= '0;
      bit_cnt    <= '0;
      sck        <= 1'b0;
      ws         <= 1'b0;
      sck_rise   <= 1'b0;
      sck_fall   <= 1'b0;
      ws_start   <= 1'b0;
      act_half   <= DIV_W'(DEF_SCK_HALF);
      act_ratio  <= RATIO_W'(DEF_WS_RATIO);
      pend_half  <= '0;
      pend_ratio <= '0;
      pend_valid <= 1'b0;
      frame_cnt  <= '0;
      rst_mic_n  <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      half_cnt  <= half_cnt_n;
      bit_cnt   <= bit_cnt_n;
      sck       <= sck_n;
      ws        <= ws_n;
      sck_rise  <= ~sck & sck_n;
      sck_fall  <= sck & ~sck_n;
      ws_start  <= frame_start;

      // apply and accept are exclusive: accept needs no pending config.
      if (apply) begin
        act_half   <= pend_half;
        act_ratio  <= pend_ratio;
        pend_valid <= 1'b0;
      end
      if (accept) begin
        if (state == OFF) begin
          act_half  <= san_half;
          act_ratio <= san_ratio;
        end else begin
          pend_half  <= san_half;
          pend_ratio <= san_ratio;
          pend_valid <= 1'b1;
        end
      end

      if (!lock_s) begin
        frame_cnt <= '0;
        rst_mic_n <= 1'b0;
      end else if (ws_start) begin
        if (frame_cnt != HOLD) frame_cnt <= frame_cnt + FC_W'(1);
        if (frame_cnt >= HOLD - FC_W'(1)) rst_mic_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mic_clk_gen.sv
// Self-checking bench for mic_clk_gen: a frame-position reference model is
// compared against the DUT on every cycle, with directed phases that pin
// frame lengths, sck periods and the reset-release timing to literal values.
module tb_mic_clk_gen;

  localparam int HOLD = 4;

  logic       clk_in = 1'b0;
  logic       rst_n, pll_lock, en, cfg_valid;
  logic [7:0] cfg_sck_half, cfg_ws_ratio;
  logic       cfg_ready, sck, sck_rise, sck_fall, ws, ws_start, rst_mic_n, busy;

  mic_clk_gen #(
    .DIV_W(8), .RATIO_W(8), .DEF_SCK_HALF(5), .DEF_WS_RATIO(64),
    .RST_HOLD_FRAMES(HOLD)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .pll_lock(pll_lock), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sck_half(cfg_sck_half), .cfg_ws_ratio(cfg_ws_ratio),
    .sck(sck), .sck_rise(sck_rise), .sck_fall(sck_fall), .ws(ws),
    .ws_start(ws_start), .rst_mic_n(rst_mic_n), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Running frames are described by a position within the frame; sck and ws
  // follow from that position and the active half-period / ratio.
  int m_mode;  // 0 off, 1 run, 2 finishing
  int m_pos, m_h, m_r, m_ph, m_pr, m_fc;
  bit m_pv, m_s1, m_ls, m_sck, m_ws, m_wss, m_rise, m_fall, m_rst;

  function automatic int san_h(input int v);
    return (v == 0) ? 1 : v;
  endfunction
  function automatic int san_r(input int v);
    int r;
    r = v - (v % 2);
    if (r < 2) r = 2;
    return r;
  endfunction

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_h = 5; m_r = 64; m_ph = 0; m_pr = 0; m_fc = 0;
      m_pv = 0; m_s1 = 0; m_ls = 0; m_sck = 0; m_ws = 0; m_wss = 0;
      m_rise = 0; m_fall = 0; m_rst = 0;
    end else begin : upd
      bit lk, acc, psck, pwss, opv;
      lk = m_ls; acc = cfg_valid && !m_pv; psck = m_sck; pwss = m_wss; opv = m_pv;
      m_ls = m_s1;
      m_s1 = pll_lock;
      if (!lk) begin
        m_fc = 0; m_rst = 0;
      end else if (pwss) begin
        if (m_fc < HOLD) m_fc++;
        if (m_fc >= HOLD) m_rst = 1;
      end
      m_wss = 0;
      if (m_mode == 0) begin
        if (acc) begin m_h = san_h(cfg_sck_half); m_r = san_r(cfg_ws_ratio); end
        m_pos = 0;
        if (en && lk) begin
          if (opv) begin m_h = m_ph; m_r = m_pr; m_pv = 0; end
          m_mode = 1; m_wss = 1;
        end
      end else begin
        if (acc) begin m_ph = san_h(cfg_sck_half); m_pr = san_r(cfg_ws_ratio); m_pv = 1; end
        if (!lk) begin
          m_mode = 0; m_pos = 0;
        end else if (m_pos == 2 * m_h * m_r - 1) begin
          if (opv) begin m_h = m_ph; m_r = m_pr; m_pv = 0; end
          m_pos = 0;
          if (en) begin m_mode = 1; m_wss = 1; end
          else m_mode = 0;
        end else begin
          m_pos++;
          m_mode = en ? 1 : 2;
        end
      end
      if (m_mode == 0) begin
        m_sck = 0; m_ws = 0;
      end else begin
        m_sck = ((m_pos / m_h) % 2) == 1;
        m_ws  = m_pos >= m_h * m_r;
      end
      m_rise = !psck && m_sck;
      m_fall = psck && !m_sck;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_in) begin
    if (rst_n) begin
      chk("sck", sck, m_sck);
      chk("ws", ws, m_ws);
      chk("ws_start", ws_start, m_wss);
      chk("sck_rise", sck_rise, m_rise);
      chk("sck_fall", sck_fall, m_fall);
      chk("rst_mic_n", rst_mic_n, m_rst);
      chk("busy", busy, m_mode != 0);
      chk("cfg_ready", cfg_ready, !m_pv);
    end
  end

  // ---------------- event monitor ----------------
  int cyc = 0;
  int wsq[$], rq[$], wq[$];
  int rr = -1;
  bit p_ws = 0, p_rst = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (ws_start) wsq.push_back(cyc);
    if (sck_rise) rq.push_back(cyc);
    if (ws && !p_ws) wq.push_back(cyc);
    if (rst_mic_n && !p_rst) rr = cyc;
    p_ws  = ws;
    p_rst = rst_mic_n;
  end

  task automatic wait_ws(input int n, input int budget, input string tag);
    int k = 0;
    while (wsq.size() < n && k < budget) begin
      @(negedge clk_in);
      k++;
    end
    chk(tag, wsq.size() >= n, 1);
  endtask

  task automatic clear_q();
    wsq.delete(); rq.delete(); wq.delete();
  endtask

  task automatic offer(input int h, input int r);
    cfg_valid = 1; cfg_sck_half = 8'(h); cfg_ws_ratio = 8'(r);
    @(negedge clk_in);
    cfg_valid = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fs, k;
    rst_n = 0; pll_lock = 0; en = 0; cfg_valid = 0; cfg_sck_half = 0; cfg_ws_ratio = 0;
    repeat (3) @(negedge clk_in);
    chk("rst_sck", sck, 0);
    chk("rst_ws", ws, 0);
    chk("rst_ws_start", ws_start, 0);
    chk("rst_mic", rst_mic_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    rst_n = 1;

    // Defaults.
    clear_q();
    pll_lock = 1; en = 1;
    wait_ws(5, 4000, "def_frames");
    if (wsq.size() >= 5 && rq.size() >= 2 && wq.size() >= 1) begin
      chk("def_frame_len", wsq[1] - wsq[0], 640);
      chk("def_sck_per", rq[1] - rq[0], 10);
      chk("def_first_rise", rq[0] - wsq[0], 5);
      chk("def_ws_low", wq[0] - wsq[0], 320);
      chk("def_rst_rel", rr, wsq[HOLD-1] + 1);
    end

    // Config offered mid-frame at bit 10.
    clear_q();
    wait_ws(1, 700, "b_sync");
    fs = (wsq.size() > 0) ? wsq[0] : 0;
    repeat (100) @(negedge clk_in);
    offer(3, 32);
    chk("b_ready_low", cfg_ready, 0);
    clear_q();
    wait_ws(3, 1200, "b_frames");
    if (wsq.size() >= 3 && rq.size() >= 2) begin
      chk("b_old_frame", wsq[0] - fs, 640);
      chk("b_new_frame", wsq[1] - wsq[0], 192);
      chk("b_new_sck_per", rq[$] - rq[$-1], 6);
    end

    // Stop, then program in OFF with out-of-range values.
    en = 0;
    k = 0;
    while (busy && k < 500) begin @(negedge clk_in); k++; end
    chk("c_stopped", busy, 0);
    offer(0, 7);
    chk("c_ready_off", cfg_ready, 1);
    clear_q();
    en = 1;
    wait_ws(3, 200, "c_frames");
    if (wsq.size() >= 3 && rq.size() >= 2) begin
      chk("c_frame_len", wsq[1] - wsq[0], 12);
      chk("c_sck_per", rq[1] - rq[0], 2);
    end

    // Lock loss mid-frame, then relock.
    repeat (5) @(negedge clk_in);
    pll_lock = 0;
    repeat (3) @(negedge clk_in);
    chk("d_busy", busy, 0);
    chk("d_sck", sck, 0);
    chk("d_ws", ws, 0);
    chk("d_rst", rst_mic_n, 0);
    rr = -1;
    clear_q();
    pll_lock = 1;
    wait_ws(5, 300, "d_frames");
    if (wsq.size() >= 5) chk("d_rst_rel", rr, wsq[HOLD-1] + 1);

    // Randomised run against the model.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk_in);
      if ($urandom_range(0, 63) == 0) en = ~en;
      if (pll_lock && $urandom_range(0, 499) == 0) pll_lock = 0;
      else if (!pll_lock && $urandom_range(0, 19) == 0) pll_lock = 1;
      cfg_valid    = ($urandom_range(0, 15) == 0);
      cfg_sck_half = 8'($urandom_range(0, 4));
      cfg_ws_ratio = 8'($urandom_range(0, 12));
    end
    cfg_valid = 0;

    // Async reset mid-frame with a pending config.
    pll_lock = 1; en = 1;
    k = 0;
    while ((!busy || !cfg_ready) && k < 1000) begin @(negedge clk_in); k++; end
    offer(2, 4);
    #2 rst_n = 0;
    #1;
    chk("f_sck", sck, 0);
    chk("f_ws", ws, 0);
    chk("f_ws_start", ws_start, 0);
    chk("f_rise", sck_rise, 0);
    chk("f_fall", sck_fall, 0);
    chk("f_rst", rst_mic_n, 0);
    chk("f_busy", busy, 0);
    chk("f_ready", cfg_ready, 1);
    repeat (2) @(negedge clk_in);
    rst_n = 1;
    clear_q();
    wait_ws(2, 1400, "f_frames");
    if (wsq.size() >= 2 && rq.size() >= 2) begin
      chk("f_frame_len", wsq[1] - wsq[0], 640);
      chk("f_sck_per", rq[1] - rq[0], 10);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mic_clk_gen.md
Name: mic_clk_gen

Overview:
Runtime-programmable microphone clock generator; successor to the fixed clk_div/clk_div_64 chain. From one fast clock it derives a 50%-duty bit clock (sck) and a frame word-select (ws) with programmable ratios. Divisor changes are glitch-free and take effect only at frame boundaries. A lock-gated reset sequencer drives rst_mic_n. Sits in clock_and_reset, fed by the 60 MHz PLL output, driving the mic array front end.

Parameters:
DIV_W, 8, width of sck half-period divisor
RATIO_W, 8, width of sck-periods-per-frame ratio
DEF_SCK_HALF, 5, reset value of active half-period (60 MHz -> 6 MHz sck)
DEF_WS_RATIO, 64, reset value of active frame ratio (even)
RST_HOLD_FRAMES, 4, frames counted after start before rst_mic_n releases (>=1)

Ports:
clk_in  in  1  sole clock
rst_n  in  1  asynchronous active-low reset
pll_lock  in  1  PLL lock, asynchronous to clk_in
en  in  1  run request
cfg_valid  in  1  config offer
cfg_ready  out  1  config accept-ready
cfg_sck_half  in  DIV_W  requested sck half-period, clk_in cycles
cfg_ws_ratio  in  RATIO_W  requested sck periods per ws frame
sck  out  1  bit clock
sck_rise  out  1  high in first clk_in cycle sck is 1
sck_fall  out  1  high in first clk_in cycle sck is 0 after a high phase
ws  out  1  word select, 0 = first half-frame
ws_start  out  1  one-cycle frame-start strobe
rst_mic_n  out  1  downstream reset, active low
busy  out  1  1 while in RUN or STOP_PEND

Behaviour:
- Reset (rst_n=0, async): sck=0, ws=0, all strobes 0, rst_mic_n=0, busy=0, cfg_ready=1; act_half=DEF_SCK_HALF, act_ratio=DEF_WS_RATIO, no pending config; state OFF.
- pll_lock passes a 2-flop synchroniser (lock_s); 2-cycle latency.
- Config sanitising on accept: half=0 -> 1; ratio<2 -> 2; odd ratio -> LSB cleared.
- Handshake: transfer when cfg_valid & cfg_ready. In OFF: written to active regs next cycle, cfg_ready stays 1. In RUN/STOP_PEND: stored as pending, cfg_ready=0 until applied at next frame boundary, then 1 the following cycle. A second offer while pending is not accepted.
- States:
  OFF: counters cleared, sck=0, ws=0. en & lock_s -> RUN.
  RUN: half_cnt counts 0..act_half-1; at act_half-1 it wraps and sck toggles. On each sck falling toggle bit_cnt increments; at act_ratio-1 it wraps to 0 (frame boundary). ws=0 for bit_cnt < act_ratio/2, else 1; ws changes only in the cycle sck falls. en=0 -> STOP_PEND. lock_s=0 -> OFF immediately.
  STOP_PEND: runs as RUN until next frame boundary, then OFF with sck=0, ws=0, no ws_start. en=1 again before boundary -> RUN, no gap. lock_s=0 -> OFF.
- Frame start: first RUN cycle after OFF and every frame boundary in RUN: ws_start=1, ws=0, bit_cnt=0, pending config copied to active regs in that same cycle (new divisors govern the following counts). Entry from OFF has sck=0 and first rise after act_half cycles.
- Timing: sck period = 2*act_half cycles; frame = 2*act_half*act_ratio cycles; ws low exactly half the frame.
- rst_mic_n: registered; cleared in the cycle after lock_s falls. Frame counter counts ws_start in RUN while lock_s=1; rst_mic_n goes 1 the cycle after the RST_HOLD_FRAMES-th ws_start and stays 1 across en toggles until lock loss or rst_n. Counter saturates and clears on lock loss.
- Simultaneous: lock loss beats en and config apply (pending config is kept); a config accept in the same cycle as a boundary is held pending for the next boundary.
- rst_n mid-frame: all outputs to reset values asynchronously; pending config discarded.

Test Plan:
- Defaults, lock=1, en=1: sck period 10 cycles; ws_start every 640; ws low 320 cycles then high 320; rst_mic_n rises 1 cycle after 4th ws_start.
- In RUN at bit_cnt 10: offer half=3, ratio=32 -> cfg_ready=0; old 640-cycle frame completes; next frame is 192 cycles, sck period 6; cfg_ready=1 after boundary.
- In OFF: offer half=0, ratio=7 -> active half=1, ratio=6; run gives sck period 2, frame 12 cycles.
- en dropped mid-frame -> frame completes, sck/ws stay 0, busy=0, no truncated frame; en re-raised before boundary -> continuous frames.
- pll_lock dropped mid-frame -> within 3 cycles: OFF, sck=0, ws=0, rst_mic_n=0; relock -> 4 more frames before release.
- rst_n pulsed mid-frame with pending config -> outputs reset asynchronously; after release, defaults active, cfg_ready=1.
